mips_inst_feeder: RTL

Buffers instruction words from a host (bench driver or loader) in a small FIFO and presents them to `MIPS_multicycle` on `extInst`/`extInst_en`, one word per fetch, aligned to the CPU's multicycle state machine. This is the driving end of the external-instruction port. It replaces the tie-off `extInst_en = 1` with a flow-controlled source, so programs can be streamed in without preloading instruction memory.

---
 rtl/mips_inst_feeder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mips_inst_feeder.sv
// rtl/mips_inst_feeder.sv - FIFO-backed instruction source for the MIPS multicycle external-instruction port
// Issues one buffered word per CPU fetch entry; NOP when idle, empty or finished.
module mips_inst_feeder #(
    parameter int                 DEPTH       = 8,
    parameter int                 STATE_W     = 4,
    parameter logic [STATE_W-1:0] FETCH_STATE = '0,
    parameter logic [31:0]        NOP         = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_data,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic                       start,
    input  logic                       flush,
    input  logic [STATE_W-1:0]         current_state,
    output logic [31:0]                extInst,
    output logic                       extInst_en,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     level,
    output logic [31:0]                issued_cnt,
    output logic [15:0]                underrun_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              last_seen_q, last_seen_d;
    logic              prev_fetch_q, prev_fetch_d;
    logic [31:0]       issued_cnt_q, issued_cnt_d;
    logic [15:0]       underrun_cnt_q, underrun_cnt_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [DEPTH-1:0]  last_mem_q, last_mem_d;

    logic empty, full, is_fetch, fetch_hit, push, pop, underrun;

    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    assign is_fetch  = (current_state == FETCH_STATE);
    assign fetch_hit = is_fetch && !prev_fetch_q;
    assign push      = in_valid && !full;
    assign pop       = (state_q == RUN) && fetch_hit && !empty;
    assign underrun  = (state_q == RUN) && fetch_hit && empty && !last_seen_q;

    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        level_d        = level_q;
        last_seen_d    = last_seen_q;
        prev_fetch_d   = is_fetch;
        issued_cnt_d   = issued_cnt_q;
        underrun_cnt_d = underrun_cnt_q;
        mem_d          = mem_q;
        last_mem_d     = last_mem_q;

        // Flush wins over everything else in the same cycle, counters excepted
        if (flush) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            last_seen_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q]      = in_data;
                last_mem_d[wr_ptr_q] = in_last;
                wr_ptr_d             = wr_ptr_q + AW'(1);
                if (in_last) last_seen_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                issued_cnt_d = issued_cnt_q + 32'd1;
            end
            if (underrun && underrun_cnt_q != 16'hFFFF)
                underrun_cnt_d = underrun_cnt_q + 16'd1;
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (pop && last_mem_q[rd_ptr_q]) state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            last_seen_q    <= 1'b0;
            prev_fetch_q   <= 1'b0;
            issued_cnt_q   <= '0;
            underrun_cnt_q <= '0;
            last_mem_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            last_seen_q    <= last_seen_d;
            prev_fetch_q   <= prev_fetch_d;
            issued_cnt_q   <= issued_cnt_d;
            underrun_cnt_q <= underrun_cnt_d;
            last_mem_q     <= last_mem_d;
            mem_q          <= mem_d;
        end
    end

    assign in_ready     = !full;
    assign extInst      = (state_q == RUN && !empty) ? mem_q[rd_ptr_q] : NOP;
    assign extInst_en   = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign level        = level_q;
    assign issued_cnt   = issued_cnt_q;
    assign underrun_cnt = underrun_cnt_q;
endmodule
